ifu_fetch: RTL and testbench

//   Instruction fetch unit directly upstream of the RV32IM core. Takes the core's pc, reads one
//   32-bit word from instruction memory over a valid/ready read channel and holds the word on

---
 rtl/ifu_fetch.sv | 116 +++++++++++
 tb/tb_ifu_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch over a valid/ready read channel.
// Misaligned pc, bus errors and timeouts complete as a faulted NOP.
module ifu_fetch #(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  TIMEOUT    = 255,
  parameter int                  TO_W       = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  global_rst_n,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  fetch_fault,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rresp_err,
  input  logic                  rvalid,
  output logic                  rready
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t                r_state;
  logic [TO_W-1:0]       r_cnt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_arvalid, r_rready, r_inst_valid, r_fault;
  logic                  w_to;
  // the counter value during a phase's last allowed cycle is TIMEOUT-1
  assign w_to        = (TIMEOUT != 0) && (r_cnt == TO_LAST);
  assign inst        = r_inst;
  assign inst_valid  = r_inst_valid;
  assign fetch_fault = r_fault;
  assign araddr      = r_araddr;
  assign arvalid     = r_arvalid;
  assign rready      = r_rready;
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_araddr     <= '0;
      r_inst       <= NOP_INST;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      if ((r_state == S_REQ || r_state == S_WAIT) && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_araddr <= pc;
          r_cnt    <= '0;
          if (pc[1:0] != 2'b00) begin
            r_state      <= S_DONE;
            r_fault      <= 1'b1;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b1;
          end else begin
            r_state   <= S_REQ;
            r_arvalid <= 1'b1;
          end
        end
        S_REQ: begin
          if (arready) begin
            r_state   <= S_WAIT;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
          end else if (w_to) begin
            r_state      <= S_DONE;
            r_arvalid    <= 1'b0;
            r_fault      <= 1'b1;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b1;
            r_cnt        <= '0;
          end
        end
        S_WAIT: begin
          if (rvalid) begin
            r_state      <= S_DONE;
            r_rready     <= 1'b0;
            r_inst       <= rresp_err ? NOP_INST : rdata;
            r_fault      <= rresp_err;
            r_inst_valid <= 1'b1;
            r_cnt        <= '0;
          end else if (w_to) begin
            r_state <= S_DRAIN;
            r_fault <= 1'b1;
            r_inst  <= NOP_INST;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          if (rvalid) begin
            r_state      <= S_DONE;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (inst_ready) begin
            r_state      <= S_IDLE;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized fetch scenarios against an outcome/latency model derived
// from the fetch rules (alignment, arready/rvalid delays vs timeout, error response).
module tb_ifu_fetch;
  localparam int          TMO = 8;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 1'b0, global_rst_n = 1'b0;
  logic [31:0] pc = '0, rdata = '0;
  logic        inst_ready = 1'b0, arready = 1'b0, rresp_err = 1'b0, rvalid = 1'b0;
  logic [31:0] inst, araddr;
  logic        inst_valid, fetch_fault, arvalid, rready;
  int          checks = 0, errors = 0;

  ifu_fetch #(.TIMEOUT(TMO), .TO_W(4)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_fault(fetch_fault), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp_err(rresp_err), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 6;
    if (arvalid !== 1'b0)     begin errors++; $display("FAIL %s arvalid got %b want 0", tag, arvalid); end
    if (rready !== 1'b0)      begin errors++; $display("FAIL %s rready got %b want 0", tag, rready); end
    if (inst_valid !== 1'b0)  begin errors++; $display("FAIL %s inst_valid got %b want 0", tag, inst_valid); end
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL %s fetch_fault got %b want 0", tag, fetch_fault); end
    if (araddr !== 32'h0)     begin errors++; $display("FAIL %s araddr got %h want 0", tag, araddr); end
    if (inst !== NOP)         begin errors++; $display("FAIL %s inst got %h want %h", tag, inst, NOP); end
  endtask

  // Precondition: the current cycle is the DUT's IDLE cycle. Leaves it in the next IDLE cycle.
  task automatic run_fetch(input logic [31:0] fpc, input int ard, input int rd,
                           input logic [31:0] data, input logic err, input int hold, input string tag);
    logic        mis, ar_to, r_to, ef;
    logic [31:0] ei;
    int          elat, earv, ar_seen, r_seen, nar, k;
    mis   = fpc[1:0] != 2'b00;
    ar_to = !mis && ard >= TMO;
    r_to  = !mis && !ar_to && rd >= TMO;
    ef    = mis || ar_to || r_to || (err && !mis && !ar_to);
    ei    = ef ? NOP : data;
    elat  = mis ? 1 : ar_to ? 1 + TMO : ard + rd + 3;
    earv  = mis ? 0 : ar_to ? TMO : ard + 1;
    ar_seen = 0; r_seen = 0; nar = 0; k = 0;
    pc = fpc;
    while (!inst_valid && k < 80) begin
      checks++;
      if (arvalid && rready) begin errors++; $display("FAIL %s overlap arvalid=%b rready=%b want not both", tag, arvalid, rready); end
      if (arvalid) begin
        nar++;
        checks++;
        if (araddr !== fpc) begin errors++; $display("FAIL %s araddr_req got %h want %h", tag, araddr, fpc); end
      end
      arready   = arvalid ? (ar_seen == ard) : 1'($urandom);
      rvalid    = rready ? (r_seen == rd) : 1'($urandom);
      rdata     = (rready && r_seen == rd) ? data : $urandom;
      rresp_err = (rready && r_seen == rd) ? err : 1'($urandom);
      inst_ready = 1'($urandom);
      if (k > 0) pc = $urandom;
      if (arvalid) ar_seen++;
      if (rready) r_seen++;
      tick();
      k++;
    end
    arready = 1'b0; rvalid = 1'b0; rresp_err = 1'b0;
    checks++;
    if (!inst_valid) begin
      errors++;
      $display("FAIL %s no inst_valid within bound got 0 want 1", tag);
    end else begin
      checks += 5;
      if (k !== elat)         begin errors++; $display("FAIL %s latency got %0d want %0d", tag, k, elat); end
      if (inst !== ei)        begin errors++; $display("FAIL %s inst got %h want %h", tag, inst, ei); end
      if (fetch_fault !== ef) begin errors++; $display("FAIL %s fault got %b want %b", tag, fetch_fault, ef); end
      if (nar !== earv)       begin errors++; $display("FAIL %s arvalid_cycles got %0d want %0d", tag, nar, earv); end
      if (araddr !== fpc)     begin errors++; $display("FAIL %s araddr got %h want %h", tag, araddr, fpc); end
      for (int h = 0; h < hold; h++) begin
        inst_ready = 1'b0;
        pc = $urandom;
        tick();
        checks++;
        if (!inst_valid || inst !== ei || fetch_fault !== ef)
          begin errors++; $display("FAIL %s hold v=%b inst=%h f=%b want v=1 inst=%h f=%b", tag, inst_valid, inst, fetch_fault, ei, ef); end
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL %s accept inst_valid got %b want 0", tag, inst_valid); end
    end
  endtask

  task automatic test_reset();
    global_rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    global_rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    run_fetch(32'h80000000, 0, 0, 32'h00500093, 1'b0, 0, "zero_wait");
    run_fetch(32'h80000004, 0, 0, 32'h00a00113, 1'b0, 1, "zero_wait_next");
  endtask

  task automatic test_delays();
    run_fetch(32'h80000008, 5, 7, 32'h002081b3, 1'b0, 10, "delays");
  endtask

  task automatic test_misaligned();
    run_fetch(32'h80000002, 0, 0, 32'hdeadbeef, 1'b0, 2, "misaligned2");
    run_fetch(32'h80000001, 0, 0, 32'hdeadbeef, 1'b0, 0, "misaligned1");
    run_fetch(32'h80000003, 0, 0, 32'hdeadbeef, 1'b0, 0, "misaligned3");
  endtask

  task automatic test_timeouts();
    run_fetch(32'h80000010, TMO + 20, 0, 32'h11111111, 1'b0, 1, "ar_timeout");
    run_fetch(32'h80000014, TMO - 1, 0, 32'h22222222, 1'b0, 0, "ar_last_cycle");
    run_fetch(32'h80000018, 0, 0, 32'h33333333, 1'b1, 1, "rresp_err");
    run_fetch(32'h8000001c, 0, TMO + 2, 32'h44444444, 1'b0, 1, "drain");
    run_fetch(32'h80000020, 0, TMO, 32'h55555555, 1'b0, 0, "drain_first");
    run_fetch(32'h80000024, 0, TMO - 1, 32'h66666666, 1'b0, 0, "r_last_cycle");
  endtask

  task automatic test_reset_mid();
    pc = 32'h80000100;
    arready = 1'b1;
    tick();
    tick();
    arready = 1'b0;
    rvalid = 1'b0;
    tick();
    checks++;
    if (rready !== 1'b1) begin errors++; $display("FAIL reset_mid pre rready got %b want 1", rready); end
    #2;
    global_rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    rvalid = 1'b1;
    rdata = 32'hbad0bad0;
    tick();
    tick();
    global_rst_n = 1'b1;
    rvalid = 1'b0;
    run_fetch(32'h80000100, 1, 2, 32'h00108093, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int i = 0; i < 40; i++) begin
      p = $urandom;
      if ($urandom % 8 != 0) p[1:0] = 2'b00;
      run_fetch(p, $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 3), $urandom,
                1'($urandom % 6 == 0), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delays();
    test_misaligned();
    test_timeouts();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
